// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared scheduler state encodings and requester indices
package hacd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RUN,
    ST_RELEASE,
    ST_ERROR
  } sched_state_e;

  localparam int REQ_FAULT    = 0;
  localparam int REQ_PREFETCH = 1;
  localparam int CNT_WIDTH    = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin selector producing a one-hot winner
module rr_arbiter2
  import hacd_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    if (req == 2'b11) begin
      // On a tie the requester that did not win last time goes first.
      winner[REQ_FAULT]    = last_grant;
      winner[REQ_PREFETCH] = ~last_grant;
    end else begin
      winner = req;
    end
  end

endmodule

// File: rtl/decomp_scheduler.sv
// rtl/decomp_scheduler.sv - arbitrates fault/prefetch jobs onto one decompressor with timeout
module decomp_scheduler
  import hacd_pkg::*;
#(
  parameter int PPN_WIDTH      = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           req_valid,
  input  logic [PPN_WIDTH-1:0] req_ppn0,
  input  logic [PPN_WIDTH-1:0] req_ppn1,
  input  logic [13:0]          req_size0,
  input  logic [13:0]          req_size1,
  output logic [1:0]           req_ready,
  output logic [1:0]           job_done,
  output logic                 job_err,
  output logic                 decomp_start,
  output logic [13:0]          comp_size,
  output logic [PPN_WIDTH-1:0] active_ppn,
  input  logic                 decomp_done,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  sched_state_e         state, state_next;
  logic                 owner;
  logic                 last_grant;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           winner;
  logic                 win_idx;
  logic [1:0]           owner_onehot;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign win_idx      = winner[REQ_PREFETCH];
  assign owner_onehot = owner ? 2'b10 : 2'b01;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      decomp_start <= 1'b0;
      comp_size    <= '0;
      active_ppn   <= '0;
    end else begin
      state        <= state_next;
      decomp_start <= (state_next == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            owner      <= win_idx;
            last_grant <= win_idx;
          end
        end
        ST_GRANT: begin
          // Requester still holds its data during the acceptance cycle.
          cnt        <= '0;
          active_ppn <= owner ? req_ppn1 : req_ppn0;
          comp_size  <= owner ? req_size1 : req_size0;
        end
        ST_RUN: begin
          if (!decomp_done && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    job_done   = 2'b00;
    job_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_valid) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        req_ready  = owner_onehot;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (decomp_done)            state_next = ST_RELEASE;
        else if (cnt == CNT_LAST)   state_next = ST_ERROR;
      end
      ST_RELEASE: begin
        if (!decomp_done) begin
          job_done   = owner_onehot;
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: begin
        job_done   = owner_onehot;
        job_err    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_decomp_scheduler.sv
// tb/tb_decomp_scheduler.sv - randomized self-checking bench against a job-level model
module tb_decomp_scheduler;

  localparam int PW = 20;
  localparam int TO = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [PW-1:0] ppn0 = '0, ppn1 = '0;
  logic [13:0]   size0 = '0, size1 = '0;
  logic [1:0]    req_ready, job_done;
  logic          job_err, decomp_start, busy;
  logic [13:0]   comp_size;
  logic [PW-1:0] active_ppn;
  logic          decomp_done = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int dec_lat  = 0;
  int dec_cnt  = 0;
  bit last_grant_m = 1'b1;
  logic [PW-1:0] ppn_m [2];
  logic [13:0]   size_m [2];

  decomp_scheduler #(.PPN_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid    (req_valid),
    .req_ppn0     (ppn0),
    .req_ppn1     (ppn1),
    .req_size0    (size0),
    .req_size1    (size1),
    .req_ready    (req_ready),
    .job_done     (job_done),
    .job_err      (job_err),
    .decomp_start (decomp_start),
    .comp_size    (comp_size),
    .active_ppn   (active_ppn),
    .decomp_done  (decomp_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Decompressor: raises done after dec_lat cycles of start (0 = never), holds it until start drops.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !decomp_start) begin
      dec_cnt     = 0;
      decomp_done = 1'b0;
    end else begin
      dec_cnt++;
      if (dec_lat != 0 && dec_cnt == dec_lat) decomp_done = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic raise_val(input int r, input logic [PW-1:0] p, input logic [13:0] s);
    ppn_m[r]  = p;
    size_m[r] = s;
    if (r == 0) begin ppn0 = p; size0 = s; end
    else        begin ppn1 = p; size1 = s; end
    req_valid[r] = 1'b1;
  endtask

  task automatic raise(input int r);
    raise_val(r, PW'($urandom), 14'($urandom));
  endtask

  function automatic logic [1:0] model_winner(input logic [1:0] rv);
    if (rv == 2'b11) return last_grant_m ? 2'b01 : 2'b10;
    return rv;
  endfunction

  task automatic run_job(input int lat, input bit late_other);
    logic [1:0] exp_w;
    int w, waited, dur, exp_dur;
    bit exp_err;
    dec_lat = lat;
    exp_w   = model_winner(req_valid);
    w       = exp_w[1] ? 1 : 0;
    waited  = 0;
    while (req_ready == 2'b00 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_eq("grant", 32'(req_ready), 32'(exp_w));
    if (req_ready == 2'b00) return;
    last_grant_m = w[0];
    req_valid[w] = 1'b0;
    if (late_other && !req_valid[1-w]) raise(1 - w);
    @(negedge clk);
    check_eq("active_ppn", 32'(active_ppn), 32'(ppn_m[w]));
    check_eq("comp_size", 32'(comp_size), 32'(size_m[w]));
    check_eq("busy_run", 32'(busy), 32'd1);
    exp_err = (lat == 0) || (lat > TO);
    exp_dur = exp_err ? TO : lat;
    dur = 0;
    while (decomp_start && dur < 200) begin
      dur++;
      @(negedge clk);
    end
    check_eq("start_len", 32'(dur), 32'(exp_dur));
    check_eq("job_done", 32'(job_done), 32'(exp_w));
    check_eq("job_err", 32'(job_err), 32'(exp_err));
    check_eq("no_early_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("done_pulse_end", 32'(job_done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("size_held", 32'(comp_size), 32'(size_m[w]));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_done"}, 32'(job_done), 32'd0);
    check_eq({tag, "_err"}, 32'(job_err), 32'd0);
    check_eq({tag, "_start"}, 32'(decomp_start), 32'd0);
    check_eq({tag, "_size"}, 32'(comp_size), 32'd0);
    check_eq({tag, "_ppn"}, 32'(active_ppn), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    check_all_zero("reset");
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_no_done", 32'(job_done), 32'd0);
    end
    rst_n = 1'b1;
    last_grant_m = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] m;
    int lat;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

    raise_val(0, 20'h12345, 14'h0400);
    run_job(20, 1'b0);

    apply_reset();
    raise(0); raise(1);
    run_job(7, 1'b0);
    run_job(9, 1'b0);
    raise(0); raise(1);
    run_job(3, 1'b0);
    run_job(2, 1'b0);

    raise(1); run_job(0, 1'b0);
    raise(0); run_job(TO, 1'b0);
    raise(1); run_job(TO + 1, 1'b0);

    raise(0); run_job(10, 1'b1);
    run_job(4, 1'b0);

    // Abort a running job with reset, then confirm the tie goes to requester 0.
    raise(0);
    dec_lat = 0;
    while (req_ready == 2'b00) @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    check_eq("mid_run_start", 32'(decomp_start), 32'd1);
    apply_reset();
    @(negedge clk);
    check_eq("post_reset_idle", 32'(busy), 32'd0);
    raise(0); raise(1);
    run_job(5, 1'b0);
    run_job(3, 1'b0);

    for (int i = 0; i < 14; i++) begin
      m = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++)
        if (m[r] && !req_valid[r]) raise(r);
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 4);
      run_job(lat, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
